// File: rtl/pixel_frame_sequencer.sv
// Pixel frame sequencer: reads GRB pixels from a buffer and emits per-bit
// encoder commands (send 0 / send 1 / hold low) for a one-wire LED chain.
// Ports: clk_i-less legacy names kept: clk, rst_n, start, num_pixels[ADDR_W],
//   pix_addr[ADDR_W] (out), pix_data[24] (in, 1-clk read latency),
//   bit_code[2], bit_sync, busy, done (all registered outputs).
// Option: define PIXSEQ_BRIGHTNESS_EN to add brightness[7:0] channel scaling.
module pixel_frame_sequencer #(
  parameter int BIT_CYCLES   = 61,
  parameter int LATCH_CYCLES = 2600,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_pixels,
`ifdef PIXSEQ_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic [1:0]        bit_code,
  output logic              bit_sync,
  output logic              busy,
  output logic              done
);

  localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int LCW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [BCW-1:0] BMAX = BCW'(BIT_CYCLES - 1);
  localparam logic [LCW-1:0] LMAX = LCW'(LATCH_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] LATCH = 2'd3;

  localparam logic [1:0] CODE_LOW = 2'b10;

  logic [1:0]        state_q, state_d;
  logic              fcnt_q, fcnt_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [LCW-1:0]    lcnt_q, lcnt_d;
  logic [4:0]        bidx_q, bidx_d;
  logic [23:0]       sh_q, sh_d;
  logic [ADDR_W-1:0] num_q, num_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        code_q, code_d;
  logic              sync_q, sync_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef PIXSEQ_BRIGHTNESS_EN
  logic [7:0]        bri_q, bri_d;

  function automatic logic [7:0] scale(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [16:0] p;
    p = {9'd0, c} * ({9'd0, b} + 17'd1);
    return p[15:8];
  endfunction
`endif

  logic [23:0] word_w;
  logic        last_w;
  logic [4:0]  bdec_w;

  always_comb begin
`ifdef PIXSEQ_BRIGHTNESS_EN
    word_w = {scale(pix_data[23:16], bri_q),
              scale(pix_data[15:8], bri_q),
              scale(pix_data[7:0], bri_q)};
`else
    word_w = pix_data;
`endif
  end

  assign last_w = (cur_q == num_q - ADDR_W'(1));
  assign bdec_w = bidx_q - 5'd1;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    bcnt_d  = bcnt_q;
    lcnt_d  = lcnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    num_d   = num_q;
    cur_d   = cur_q;
    addr_d  = addr_q;
    code_d  = code_q;
    sync_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef PIXSEQ_BRIGHTNESS_EN
    bri_d   = bri_q;
`endif
    unique case (1'b1)
      (state_q == IDLE): begin
        code_d = CODE_LOW;
        if (start) begin
          num_d  = num_pixels;
          busy_d = 1'b1;
          addr_d = '0;
          cur_d  = '0;
          fcnt_d = 1'b0;
          bcnt_d = '0;
          lcnt_d = '0;
`ifdef PIXSEQ_BRIGHTNESS_EN
          bri_d  = brightness;
`endif
          state_d = (num_pixels == '0) ? LATCH : FETCH;
        end
      end
      (state_q == FETCH): begin
        // first cycle presents address, second waits out read latency
        if (fcnt_q) begin
          state_d = SHIFT;
          sh_d    = word_w;
          bidx_d  = 5'd23;
          code_d  = {1'b0, word_w[23]};
          sync_d  = 1'b1;
          bcnt_d  = '0;
        end else begin
          fcnt_d = 1'b1;
        end
      end
      (state_q == SHIFT): begin
        if (bcnt_q == BMAX) begin
          bcnt_d = '0;
          if (bidx_q == 5'd0) begin
            if (last_w) begin
              state_d = LATCH;
              code_d  = CODE_LOW;
              lcnt_d  = '0;
            end else begin
              // next pixel was prefetched during bit 0
              cur_d  = cur_q + ADDR_W'(1);
              sh_d   = word_w;
              bidx_d = 5'd23;
              code_d = {1'b0, word_w[23]};
              sync_d = 1'b1;
            end
          end else begin
            bidx_d = bdec_w;
            code_d = {1'b0, sh_q[bdec_w]};
            sync_d = 1'b1;
            // entering bit 0: present the next pixel address
            if (bidx_q == 5'd1 && !last_w) begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      (state_q == LATCH): begin
        code_d = CODE_LOW;
        if (lcnt_q == LMAX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          lcnt_d = lcnt_q + LCW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = CODE_LOW;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= 1'b0;
      bcnt_q  <= '0;
      lcnt_q  <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      num_q   <= '0;
      cur_q   <= '0;
      addr_q  <= '0;
      code_q  <= CODE_LOW;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PIXSEQ_BRIGHTNESS_EN
      bri_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
      lcnt_q  <= lcnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      num_q   <= num_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      code_q  <= code_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PIXSEQ_BRIGHTNESS_EN
      bri_q   <= bri_d;
`endif
    end
  end

  assign pix_addr = addr_q;
  assign bit_code = code_q;
  assign bit_sync = sync_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed bench for pixel_frame_sequencer: framing, bit timing,
// prefetch order, zero-length frames, start masking and async reset.
module tb_pixel_frame_sequencer;
  localparam int BC = 61;
  localparam int LC = 2600;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_pixels = '0;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data;
  logic [1:0]    bit_code;
  logic          bit_sync;
  logic          busy;
  logic          done;
`ifdef PIXSEQ_BRIGHTNESS_EN
  logic [7:0]    brightness = 8'd255;
`endif

  int checks = 0;
  int errors = 0;

  pixel_frame_sequencer #(
    .BIT_CYCLES(BC),
    .LATCH_CYCLES(LC),
    .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_pixels(num_pixels),
`ifdef PIXSEQ_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .pix_addr(pix_addr),
    .pix_data(pix_data),
    .bit_code(bit_code),
    .bit_sync(bit_sync),
    .busy(busy),
    .done(done)
  );

  always #10 clk = ~clk;

  logic [23:0] mem [256];
  always @(posedge clk) pix_data <= mem[pix_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         sync_cyc[$];
  logic [1:0] sync_code[$];
  int         addr_log[$];
  int         done_log[$];
  int         busy_rise[$];
  logic       done_busy[$];
  int         bad_chg;
  int         not_idle;
  logic [1:0] prev_code = 2'b10;
  logic       prev_busy = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (bit_sync) begin
      sync_cyc.push_back(cyc);
      sync_code.push_back(bit_code);
    end
    if (bit_code !== prev_code && !bit_sync && bit_code !== 2'b10)
      bad_chg++;
    if (bit_code !== 2'b10) not_idle++;
    if (busy && !prev_busy) busy_rise.push_back(cyc);
    if (busy && (!prev_busy || pix_addr !== prev_addr))
      addr_log.push_back(int'(pix_addr));
    if (done) begin
      done_log.push_back(cyc);
      done_busy.push_back(busy);
    end
    prev_code = bit_code;
    prev_busy = busy;
    prev_addr = pix_addr;
  end

  task automatic clear_logs();
    sync_cyc.delete();
    sync_code.delete();
    addr_log.delete();
    done_log.delete();
    busy_rise.delete();
    done_busy.delete();
    bad_chg = 0;
    not_idle = 0;
  endtask

  task automatic start_frame(input int n, output int c0);
    @(negedge clk);
    clear_logs();
    num_pixels = AW'(n);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_log.size() > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bit_code !== 2'b10) begin
      errors++;
      $display("FAIL rst_code got=%b exp=10", bit_code);
    end
    checks++;
    if (bit_sync !== 1'b0) begin
      errors++;
      $display("FAIL rst_sync got=%b exp=0", bit_sync);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got=%b exp=0", done);
    end
    checks++;
    if (pix_addr !== '0) begin
      errors++;
      $display("FAIL rst_addr got=%0d exp=0", pix_addr);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_pixel();
    int c0;
    bit ok;
    int bad;
    logic [23:0] w;
    logic [1:0] e;
    w = 24'hA50000;
    mem[0] = w;
    start_frame(1, c0);
    wait_done(6000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_timeout got=no_done exp=done");
    end
    checks++;
    if (busy_rise.size() != 1 || busy_rise[0] != c0 + 1) begin
      errors++;
      $display("FAIL single_busy_rise got=%p exp=%0d", busy_rise, c0 + 1);
    end
    checks++;
    if (addr_log.size() != 1 || addr_log[0] != 0) begin
      errors++;
      $display("FAIL single_addr got=%p exp={0}", addr_log);
    end
    checks++;
    if (sync_cyc.size() != 24) begin
      errors++;
      $display("FAIL single_nsync got=%0d exp=24", sync_cyc.size());
    end
    if (sync_cyc.size() == 24 && done_log.size() > 0) begin
      checks++;
      if (sync_cyc[0] != c0 + 3) begin
        errors++;
        $display("FAIL single_first_sync got=%0d exp=%0d",
                 sync_cyc[0], c0 + 3);
      end
      bad = 0;
      for (int i = 0; i < 24; i++) begin
        e = {1'b0, w[23-i]};
        if (sync_code[i] !== e) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL single_bits got=%0d_wrong exp=0", bad);
      end
      bad = 0;
      for (int i = 1; i < 24; i++)
        if (sync_cyc[i] - sync_cyc[i-1] != BC) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL single_spacing got=%0d_bad exp=0", bad);
      end
      checks++;
      if (done_log[0] - sync_cyc[0] != 24 * BC + LC) begin
        errors++;
        $display("FAIL single_len got=%0d exp=%0d",
                 done_log[0] - sync_cyc[0], 24 * BC + LC);
      end
    end
    checks++;
    if (bad_chg != 0) begin
      errors++;
      $display("FAIL single_hold got=%0d exp=0", bad_chg);
    end
    checks++;
    if (done_busy.size() != 1 || done_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_done_busy got=%p exp={0}", done_busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || bit_code !== 2'b10) begin
      errors++;
      $display("FAIL single_after got=%b/%b exp=0/10", done, bit_code);
    end
  endtask

  task automatic test_three_pixels();
    int c0;
    bit ok;
    int bad;
    logic [23:0] w;
    logic [1:0] e;
    mem[0] = 24'h123456;
    mem[1] = 24'hFEDCBA;
    mem[2] = 24'h0F0F0F;
    start_frame(3, c0);
    wait_done(9000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL multi_timeout got=no_done exp=done");
    end
    checks++;
    if (addr_log.size() != 3 || addr_log[0] != 0 ||
        addr_log[1] != 1 || addr_log[2] != 2) begin
      errors++;
      $display("FAIL multi_addr got=%p exp={0,1,2}", addr_log);
    end
    checks++;
    if (sync_cyc.size() != 72) begin
      errors++;
      $display("FAIL multi_nsync got=%0d exp=72", sync_cyc.size());
    end
    if (sync_cyc.size() == 72 && done_log.size() > 0) begin
      bad = 0;
      for (int i = 0; i < 72; i++) begin
        w = mem[i / 24];
        e = {1'b0, w[23 - (i % 24)]};
        if (sync_code[i] !== e) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL multi_bits got=%0d_wrong exp=0", bad);
      end
      bad = 0;
      for (int i = 1; i < 72; i++)
        if (sync_cyc[i] - sync_cyc[i-1] != BC) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL multi_spacing got=%0d_bad exp=0", bad);
      end
      checks++;
      if (done_log[0] - sync_cyc[0] != 4392 + LC) begin
        errors++;
        $display("FAIL multi_len got=%0d exp=%0d",
                 done_log[0] - sync_cyc[0], 4392 + LC);
      end
    end
    checks++;
    if (bad_chg != 0) begin
      errors++;
      $display("FAIL multi_hold got=%0d exp=0", bad_chg);
    end
  endtask

  task automatic test_zero_pixels();
    int c0;
    bit ok;
    start_frame(0, c0);
    wait_done(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL zero_timeout got=no_done exp=done");
    end
    checks++;
    if (sync_cyc.size() != 0) begin
      errors++;
      $display("FAIL zero_nsync got=%0d exp=0", sync_cyc.size());
    end
    checks++;
    if (not_idle != 0) begin
      errors++;
      $display("FAIL zero_code got=%0d_cycles exp=0", not_idle);
    end
    checks++;
    if (done_log.size() != 1 || done_log[0] != c0 + 1 + LC) begin
      errors++;
      $display("FAIL zero_len got=%p exp=%0d", done_log, c0 + 1 + LC);
    end
  endtask

  task automatic test_start_ignored();
    int c0;
    bit ok;
    mem[0] = 24'h5A5A5A;
    start_frame(1, c0);
    repeat (200) @(negedge clk);
    num_pixels = AW'(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(6000, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ign_timeout got=no_done exp=done");
    end
    checks++;
    if (sync_cyc.size() != 24) begin
      errors++;
      $display("FAIL ign_nsync got=%0d exp=24", sync_cyc.size());
    end
    if (sync_cyc.size() > 0 && done_log.size() > 0) begin
      checks++;
      if (done_log[0] - sync_cyc[0] != 24 * BC + LC) begin
        errors++;
        $display("FAIL ign_len got=%0d exp=%0d",
                 done_log[0] - sync_cyc[0], 24 * BC + LC);
      end
    end
    checks++;
    if (busy_rise.size() != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_refire got=%0d/%b exp=1/0",
               busy_rise.size(), busy);
    end
  endtask

  task automatic test_reset_midframe();
    int c0;
    bit ok;
    mem[0] = 24'hFFFFFF;
    mem[1] = 24'hFFFFFF;
    start_frame(2, c0);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sync_cyc.size() >= 35) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_reach got=%0d exp=35", sync_cyc.size());
    end
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (bit_code !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got=%b/%b exp=10/0", bit_code, busy);
    end
    checks++;
    if (bit_sync !== 1'b0 || done !== 1'b0 || pix_addr !== '0) begin
      errors++;
      $display("FAIL mid_rst_misc got=%b/%b/%0d exp=0/0/0",
               bit_sync, done, pix_addr);
    end
    @(negedge clk);
    @(negedge clk);
    clear_logs();
    mem[0] = 24'h00FF00;
    rst_n = 1'b1;
    num_pixels = AW'(1);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(6000, ok);
    checks++;
    if (!ok || sync_cyc.size() != 24) begin
      errors++;
      $display("FAIL mid_restart got=%0d_syncs exp=24", sync_cyc.size());
    end
    if (sync_cyc.size() > 0 && done_log.size() > 0) begin
      checks++;
      if (sync_cyc[0] != c0 + 3 ||
          done_log[0] - sync_cyc[0] != 24 * BC + LC) begin
        errors++;
        $display("FAIL mid_restart_time got=%0d/%0d exp=%0d/%0d",
                 sync_cyc[0], done_log[0] - sync_cyc[0],
                 c0 + 3, 24 * BC + LC);
      end
    end
  endtask

`ifdef PIXSEQ_BRIGHTNESS_EN
  task automatic test_brightness();
    int c0;
    bit ok;
    logic [23:0] got;
    mem[0] = 24'hFF8001;
    brightness = 8'd127;
    start_frame(1, c0);
    wait_done(6000, ok);
    got = '0;
    for (int i = 0; i < 24 && i < sync_cyc.size(); i++)
      got = {got[22:0], sync_code[i][0]};
    checks++;
    // (255*128)>>8=7F, (128*128)>>8=40, (1*128)>>8=00
    if (!ok || got !== 24'h7F4000) begin
      errors++;
      $display("FAIL bright_word got=%h exp=7f4000", got);
    end
    brightness = 8'd255;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_single_pixel();
    test_three_pixels();
    test_zero_pixels();
    test_start_ignored();
    test_reset_midframe();
`ifdef PIXSEQ_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
